// File: rtl/decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, ack 17 edges after req is first sampled high.
// req/ack four-phase handshake; result held while req stays high, dropping req mid-run aborts silently.
module decrypt_iter #(
    parameter int N_K = 64,
    parameter int N_B = 64,
    parameter int N_R = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] c,
    output logic [N_B-1:0] m,
    input  logic           req,
    output logic           ack
);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Each S-box packed row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
    // Rounds whose right-rotation is two places rather than one.
    localparam logic [15:0] RS2 = 16'h3F7E;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] l, r;
    logic [55:0] cd;
    logic [3:0]  rnd;
    logic        cap_en, rnd_en, fin_en, ack_clr;

    logic [63:0] ip_c, pre_fp, fp_out;
    logic [55:0] pc1_k;
    logic [47:0] kr, er, x48;
    logic [31:0] s_out, f_out, new_l, new_r;
    logic [27:0] c_rot, d_rot;
    logic        unused_parity;

    assign unused_parity = ^{k[56], k[48], k[40], k[32], k[24], k[16], k[8], k[0]};

    for (genvar i = 0; i < 64; i++) begin : g_p64
        assign ip_c[63-i]   = c[64-IP_T[i]];
        assign fp_out[63-i] = pre_fp[64-FP_T[i]];
    end
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_k[55-i] = k[64-PC1_T[i]];
    end
    for (genvar i = 0; i < 48; i++) begin : g_p48
        assign kr[47-i] = cd[56-PC2_T[i]];
        assign er[47-i] = r[32-E_T[i]];
    end
    for (genvar i = 0; i < 32; i++) begin : g_p
        assign f_out[31-i] = s_out[32-P_T[i]];
    end
    for (genvar s = 0; s < 8; s++) begin : g_sbox
        logic [5:0] six;
        assign six = x48[47-6*s -: 6];
        assign s_out[31-4*s -: 4] = SBOX[s][{~{six[5], six[0], six[4:1]}, 2'b00} +: 4];
    end

    assign x48    = er ^ kr;
    assign new_l  = r;
    assign new_r  = l ^ f_out;
    assign pre_fp = {new_r, new_l};

    // Inverse schedule: start at C16D16 == PC1(k) and walk backwards.
    assign c_rot = RS2[rnd] ? {cd[29:28], cd[55:30]} : {cd[28], cd[55:29]};
    assign d_rot = RS2[rnd] ? {cd[1:0], cd[27:2]}    : {cd[0], cd[27:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        rnd_en    = 1'b0;
        fin_en    = 1'b0;
        ack_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cap_en    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else begin
                    rnd_en = 1'b1;
                    if (rnd == 4'(N_R - 1)) begin
                        fin_en    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!req) begin
                    ack_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l   <= '0;
            r   <= '0;
            cd  <= '0;
            rnd <= '0;
            m   <= '0;
            ack <= 1'b0;
        end else begin
            if (cap_en) begin
                l   <= ip_c[63:32];
                r   <= ip_c[31:0];
                cd  <= pc1_k;
                rnd <= '0;
            end
            if (rnd_en) begin
                l   <= new_l;
                r   <= new_r;
                cd  <= {c_rot, d_rot};
                rnd <= rnd + 4'd1;
            end
            if (fin_en) begin
                m   <= fp_out;
                ack <= 1'b1;
            end
            if (ack_clr) ack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decrypt_iter.sv
// Scoreboard bench for decrypt_iter: a table-driven DES encryption model produces ciphertexts,
// the expected plaintexts are queued, and a monitor checks them when ack rises.
module tb_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] k, c, m;
    logic        req, ack;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_m;

    decrypt_iter dut (.clk(clk), .rst(rst), .k(k), .c(c), .m(m), .req(req), .ack(ack));

    always #5 clk = ~clk;

    int ip_t[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                    64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                    37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int e_t[$] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t[$] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int ls_t[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] sbox_t[8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Output bit n (1-based from MSB) takes input bit t[n]; result right-aligned.
    function automatic logic [63:0] permute(input logic [63:0] x, input int inw, input int t[$]);
        logic [63:0] res = 64'd0;
        foreach (t[i]) res = (res << 1) | ((x >> (inw - t[i])) & 64'd1);
        return res;
    endfunction

    function automatic logic [31:0] sboxes(input logic [47:0] x);
        logic [31:0] res = 32'd0;
        int six, row, col;
        for (int s = 0; s < 8; s++) begin
            six = int'((x >> (42 - 6 * s)) & 48'h3F);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            res = (res << 4) | 32'((sbox_t[s] >> (4 * (63 - (row * 16 + col)))) & 256'hF);
        end
        return res;
    endfunction

    function automatic logic [63:0] des_encrypt(input logic [63:0] key, input logic [63:0] blk);
        logic [55:0] cd;
        logic [27:0] cc, dd;
        logic [47:0] ks[16];
        logic [63:0] t;
        logic [31:0] l, r, f, tmp;
        cd = 56'(permute(key, 64, pc1_t));
        cc = cd[55:28];
        dd = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            cc = (cc << ls_t[i]) | (cc >> (28 - ls_t[i]));
            dd = (dd << ls_t[i]) | (dd >> (28 - ls_t[i]));
            ks[i] = 48'(permute({8'h00, cc, dd}, 56, pc2_t));
        end
        t = permute(blk, 64, ip_t);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            f   = 32'(permute({32'd0, sboxes(48'(permute({32'd0, r}, 32, e_t)) ^ ks[i])}, 32, p_t));
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        return permute({r, l}, 64, fp_t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    // Monitor: pops one expectation per rising ack, checks m stays put while ack is held.
    initial begin
        logic        ack_q = 1'b0;
        logic [63:0] m_q = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ack && !ack_q) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack actual=m %h required=no ack", m);
                    end else begin
                        chk("plaintext", m, exp_q.pop_front());
                    end
                end else if (ack && ack_q) begin
                    chk("m_hold", m, m_q);
                end
            end
            ack_q = ack;
            m_q   = m;
        end
    end

    task automatic do_op(input logic [63:0] kk, input logic [63:0] cc, input logic [63:0] ee,
                         input int hold, input bit scramble);
        int  n = 0;
        bit  done = 1'b0;
        @(negedge clk);
        k   = kk;
        c   = cc;
        req = 1'b1;
        exp_q.push_back(ee);
        last_m = ee;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && scramble) begin
                k = {$urandom, $urandom};
                c = {$urandom, $urandom};
            end
            if (ack) done = 1'b1;
        end
        chk("latency", 64'(n), 64'd17);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_drop", 64'(ack), 64'd0);
    endtask

    localparam logic [63:0] STD_K = 64'h133457799BBCDFF1;
    localparam logic [63:0] STD_C = 64'h85E813540F0AB405;
    localparam logic [63:0] STD_M = 64'h0123456789ABCDEF;
    localparam logic [63:0] NIST_K = 64'h0E329232EA6D0D73;
    localparam logic [63:0] NIST_M = 64'h8787878787878787;

    initial begin
        logic [63:0] x, kk;
        int          acks;
        rst = 1'b1;
        req = 1'b0;
        k   = '0;
        c   = '0;
        last_m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_m", m, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(STD_K, STD_C, STD_M, 10, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_reset_ack", 64'(ack), 64'd0);
        chk("idle_reset_m", m, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // NIST vector with inputs scrambled after capture, then back-to-back standard vector.
        do_op(NIST_K, 64'd0, NIST_M, 0, 1'b1);
        do_op(STD_K, STD_C, STD_M, 2, 1'b0);

        // Reset during round 7.
        @(negedge clk);
        k   = STD_K;
        c   = STD_C;
        req = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("run_reset_ack", 64'(ack), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        acks = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        chk("run_reset_quiet", 64'(acks), 64'd0);
        chk("run_reset_m", m, 64'd0);
        do_op(NIST_K, 64'd0, NIST_M, 1, 1'b0);

        // Abort at round 9.
        @(negedge clk);
        k   = {$urandom, $urandom};
        c   = {$urandom, $urandom};
        req = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        acks = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        chk("abort_ack", 64'(acks), 64'd0);
        chk("abort_m", m, last_m);
        do_op(STD_K, STD_C, STD_M, 0, 1'b0);

        x = {$urandom, $urandom};
        do_op(64'd0, des_encrypt(64'd0, x), x, 1, 1'b0);
        x = {$urandom, $urandom};
        do_op('1, des_encrypt('1, x), x, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            kk = {$urandom, $urandom};
            x  = {$urandom, $urandom};
            do_op(kk, des_encrypt(kk, x), x, $urandom_range(0, 3), i[0]);
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decrypt_iter.md
Name: decrypt_iter

Overview:
Iterative DES decryption core: one Feistel round per clock, 16 rounds, with a req/ack four-phase handshake. It is the inverse partner of the iterative encryption core. Ciphertext and key are captured at request. The inverse key schedule is generated on the fly by right-rotating the PC1 halves. The plaintext is registered and held while ack is high. It reuses the shared perm_IP, perm_FP, perm_PC1, perm_PC2, split_2, merge_2 and round building blocks from params.h-based designs.

Parameters:
N_K, 64 (`N_K from params.h), cipher key width incl. parity bits
N_B, 64 (`N_B from params.h), block width
N_R, 16 (`N_R from params.h), number of Feistel rounds

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
k  input  N_K  cipher key; sampled only at request capture
c  input  N_B  ciphertext; sampled only at request capture
m  output  N_B  plaintext; registered, valid while ack=1
req  input  1  request; held high until ack seen, then dropped
ack  output  1  acknowledge; registered

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, ack=0, m=0, rnd=0, L/R/CD registers=0. rst has priority over every other event, including mid-run.
- State registers:
  - L, R: 32 bits each.
  - CD: 56 bits (C = CD[55:28], D = CD[27:0]).
  - rnd: 4 bits.
  - FSM states: IDLE, RUN, DONE.
- IDLE, req=1 at an edge:
  - {L,R} <= split_2(perm_IP(c)).
  - CD <= perm_PC1(k). This equals C16D16.
  - rnd <= 0; go to RUN.
  - req=0: stay in IDLE; ack=0.
- RUN, each edge with req=1:
  - Round key K = perm_PC2(CD).
  - {L,R} <= round(L,R,K).
  - C and D are each rotated right independently by RS[rnd].
  - RS[0..15] = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1,1. Total = 28, so CD returns to PC1(k).
  - rnd <= rnd+1 (4-bit, no wrap used).
- RUN, round 15 (rnd==N_R-1):
  - m <= perm_FP(merge_2(R16,L16)), i.e. the swapped halves of the new round output.
  - ack <= 1; go to DONE.
- Latency: the capture edge plus 16 round edges. ack is first high after the 17th rising edge at which req was sampled high.
- DONE:
  - m and ack are held stable while req=1.
  - On an edge with req=0: ack <= 0, go to IDLE. m keeps its last value.
- req dropped during RUN (protocol violation): abort at that edge. State <= IDLE, ack stays 0, m unchanged, no partial result is exposed.
- req held high after a DONE→IDLE transition is impossible, because leaving DONE requires req=0. A new request is accepted at the first edge in IDLE with req=1, so back-to-back operations cost one idle edge.
- k and c may change freely after capture; they do not affect the result.
- Round key is derived from registered CD only. No combinational path from k/c to m/ack.
- Functional invariant: decrypt_iter(k, encrypt(k,x)) == x for all k, x.

Test Plan:
- Reset: assert rst for 2 cycles mid-idle -> ack=0, m=0x0000000000000000. Then assert rst at round 7 of a run -> ack stays 0, FSM in IDLE, next request completes normally.
- Standard vector: k=0x133457799BBCDFF1, c=0x85E813540F0AB405, req=1 -> after 17 edges ack=1, m=0x0123456789ABCDEF. Check that ack is not high at edge 16.
- NIST vector: k=0x0E329232EA6D0D73, c=0x0000000000000000 -> m=0x8787878787878787. Change k and c to random values after the capture edge -> result unchanged.
- Handshake: hold req high 10 cycles after ack -> m and ack stable. Drop req -> ack=0 one edge later. Raise req with a new vector the next cycle -> correct second result.
- Abort: drop req at round 9, then re-request with the standard vector -> ack=0 throughout the aborted run, and the second run yields 0x0123456789ABCDEF after 17 edges.
- Round-trip: 200 random (k,x) pairs, encrypt with the encryption core, then decrypt here -> m==x for every pair; also the all-zero and all-ones key.
